// File: rtl/center_color_sampler.sv
// Averages R/G/B over a 2^K x 2^K window around each of nine sticker centres for one full frame.
// Results and the full-window mask update together with a one-cycle Done on the closing start-of-frame.
module center_color_sampler #(
  parameter int K  = 2,
  parameter int CW = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              gotCenters,
  input  logic [98:0]       BlockX,
  input  logic [98:0]       BlockY,
  input  logic              iSOF,
  input  logic              iDVAL,
  input  logic [10:0]       iX,
  input  logic [10:0]       iY,
  input  logic [CW-1:0]     iR,
  input  logic [CW-1:0]     iG,
  input  logic [CW-1:0]     iB,
  output logic              Busy,
  output logic              Done,
  output logic [9*3*CW-1:0] Color_Out,
  output logic [8:0]        Full_Mask
);

  localparam int NB    = 9;
  localparam int SW    = CW + 2*K;
  localparam int CNTW  = 2*K + 1;
  localparam int H     = 1 << (K-1);
  localparam int NFULL = 1 << (2*K);
  localparam logic [CNTW-1:0] FULL_CNT = NFULL[CNTW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACCUM} state_t;

  state_t               state_q, state_d;
  logic [10:0]          cx_q    [NB];
  logic [10:0]          cx_d    [NB];
  logic [10:0]          cy_q    [NB];
  logic [10:0]          cy_d    [NB];
  logic [SW-1:0]        sum_r_q [NB];
  logic [SW-1:0]        sum_r_d [NB];
  logic [SW-1:0]        sum_g_q [NB];
  logic [SW-1:0]        sum_g_d [NB];
  logic [SW-1:0]        sum_b_q [NB];
  logic [SW-1:0]        sum_b_d [NB];
  logic [CNTW-1:0]      cnt_q   [NB];
  logic [CNTW-1:0]      cnt_d   [NB];
  logic                 done_q, done_d;
  logic [9*3*CW-1:0]    color_q, color_d;
  logic [NB-1:0]        mask_q, mask_d;

  logic [NB-1:0]        hit;
  logic                 sof_px;
  logic                 accum_en;

  // Returns {lo, hi}: lo saturates at 0, hi clamps at 2047.
  function automatic logic [21:0] win_bounds(input logic [10:0] c);
    logic [10:0] lo;
    logic [11:0] hi_ext;
    lo     = (c < 11'(H)) ? 11'd0 : c - 11'(H);
    hi_ext = {1'b0, c} + 12'(H-1);
    return {lo, (hi_ext[11] ? 11'h7FF : hi_ext[10:0])};
  endfunction

  always_comb begin
    logic [21:0] bx;
    logic [21:0] by;
    hit = '0;
    bx  = '0;
    by  = '0;
    for (int i = 0; i < NB; i++) begin
      bx = win_bounds(cx_q[i]);
      by = win_bounds(cy_q[i]);
      hit[i] = (iX >= bx[21:11]) && (iX <= bx[10:0]) &&
               (iY >= by[21:11]) && (iY <= by[10:0]);
    end
  end

  assign sof_px = iSOF & iDVAL;

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    sum_r_d  = sum_r_q;
    sum_g_d  = sum_g_q;
    sum_b_d  = sum_b_q;
    cnt_d    = cnt_q;
    color_d  = color_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
    accum_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start && gotCenters) begin
          for (int i = 0; i < NB; i++) begin
            cx_d[i]    = BlockX[11*i +: 11];
            cy_d[i]    = BlockY[11*i +: 11];
            sum_r_d[i] = '0;
            sum_g_d[i] = '0;
            sum_b_d[i] = '0;
            cnt_d[i]   = '0;
          end
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (sof_px) begin
          accum_en = 1'b1;
          state_d  = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // The closing SOF pixel belongs to the next frame, so it is not summed.
        if (sof_px) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          for (int i = 0; i < NB; i++) begin
            color_d[3*CW*i +: 3*CW] = {sum_r_q[i][SW-1:2*K],
                                       sum_g_q[i][SW-1:2*K],
                                       sum_b_q[i][SW-1:2*K]};
            mask_d[i] = (cnt_q[i] == FULL_CNT);
          end
        end else if (iDVAL) begin
          accum_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sums stop growing once the window count is full, so they cannot overflow.
    if (accum_en) begin
      for (int i = 0; i < NB; i++) begin
        if (hit[i] && (cnt_q[i] != FULL_CNT)) begin
          sum_r_d[i] = sum_r_q[i] + SW'(iR);
          sum_g_d[i] = sum_g_q[i] + SW'(iG);
          sum_b_d[i] = sum_b_q[i] + SW'(iB);
          cnt_d[i]   = cnt_q[i] + CNTW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      color_q <= '0;
      mask_q  <= '0;
      for (int i = 0; i < NB; i++) begin
        cx_q[i]    <= '0;
        cy_q[i]    <= '0;
        sum_r_q[i] <= '0;
        sum_g_q[i] <= '0;
        sum_b_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      color_q <= color_d;
      mask_q  <= mask_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      sum_r_q <= sum_r_d;
      sum_g_q <= sum_g_d;
      sum_b_q <= sum_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign Color_Out = color_q;
  assign Full_Mask = mask_q;

endmodule

// File: tb/tb_center_color_sampler.sv
// Directed bench for center_color_sampler (K=2, CW=10): table of frame scenarios plus
// hand-written sequences for ignored Starts, Start on the Done cycle and mid-frame reset.
module tb_center_color_sampler;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Start;
  logic         gotCenters;
  logic [98:0]  BlockX;
  logic [98:0]  BlockY;
  logic         iSOF;
  logic         iDVAL;
  logic [10:0]  iX;
  logic [10:0]  iY;
  logic [9:0]   iR;
  logic [9:0]   iG;
  logic [9:0]   iB;
  logic         Busy;
  logic         Done;
  logic [269:0] Color_Out;
  logic [8:0]   Full_Mask;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  center_color_sampler #(.K(2), .CW(10)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .gotCenters(gotCenters),
    .BlockX(BlockX), .BlockY(BlockY), .iSOF(iSOF), .iDVAL(iDVAL),
    .iX(iX), .iY(iY), .iR(iR), .iG(iG), .iB(iB),
    .Busy(Busy), .Done(Done), .Color_Out(Color_Out), .Full_Mask(Full_Mask)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (Done === 1'b1) done_cnt <= done_cnt + 1;

  typedef struct {
    int           mode;
    bit           clip;
    int           exlo;
    int           exhi;
    logic [269:0] exp_color;
    logic [8:0]   exp_mask;
  } vec_t;

  localparam int NV = 4;
  vec_t tv [NV];

  localparam logic [29:0] WHITE = {10'd1023, 10'd1023, 10'd1023};

  task automatic chk(input string name, input logic [269:0] act, input logic [269:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [269:0] all9(input logic [29:0] v);
    logic [269:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[30*i +: 30] = v;
    return r;
  endfunction

  function automatic logic [29:0] col(input int mode, input int x, input int y);
    case (mode)
      0: return {10'd512, 10'd256, 10'd128};
      1: return (x >= 108 && x <= 111 && y >= 108 && y <= 111) ? {10'd1023, 20'd0} : 30'd0;
      2: return {10'd800, 20'd0};
      default: return 30'd0;
    endcase
  endfunction

  task automatic pix(input logic sof, input int x, input int y, input logic [29:0] c);
    @(negedge Clk);
    iSOF  = sof;
    iDVAL = 1'b1;
    iX    = 11'(x);
    iY    = 11'(y);
    {iR, iG, iB} = c;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      iSOF  = 1'b0;
      iDVAL = 1'b0;
    end
  endtask

  // Pixel 200 of every frame carries a Start pulse, which a busy sampler must ignore.
  task automatic frame(input int mode, input int lo, input int hi, input bit first_sof);
    int k;
    k = 0;
    for (int y = lo; y <= hi; y++) begin
      for (int x = lo; x <= hi; x++) begin
        pix(first_sof && (k == 0), x, y, col(mode, x, y));
        Start = (k == 200);
        k++;
      end
    end
    Start = 1'b0;
  endtask

  task automatic set_centres(input bit clip);
    for (int i = 0; i < 9; i++) begin
      BlockX[11*i +: 11] = 11'(90 + 20*(i % 3));
      BlockY[11*i +: 11] = 11'(90 + 20*(i / 3));
    end
    if (clip) begin
      BlockX[10:0] = 11'd1;
      BlockY[10:0] = 11'd1;
    end
  endtask

  task automatic run_vec(input int idx, input bit start_on_done);
    int d0;
    d0 = done_cnt;
    set_centres(tv[idx].clip);
    gotCenters = 1'b1;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    chk($sformatf("v%0d_busy_after_start", idx), 270'(Busy), 270'(1));
    // Pixels before the first SOF are not part of the sampled frame.
    repeat (3) pix(1'b0, 110, 110, WHITE);
    frame(tv[idx].mode, 86, 133, 1'b1);
    if (tv[idx].exhi >= tv[idx].exlo) frame(tv[idx].mode, tv[idx].exlo, tv[idx].exhi, 1'b0);
    pix(1'b1, 110, 110, WHITE);
    @(negedge Clk);
    chk($sformatf("v%0d_done_pulse", idx), 270'(Done), 270'(1));
    chk($sformatf("v%0d_busy_at_done", idx), 270'(Busy), 270'(0));
    chk($sformatf("v%0d_color", idx), Color_Out, tv[idx].exp_color);
    chk($sformatf("v%0d_mask", idx), 270'(Full_Mask), 270'(tv[idx].exp_mask));
    iSOF  = 1'b0;
    iDVAL = 1'b0;
    Start = start_on_done;
    @(negedge Clk);
    Start = 1'b0;
    chk($sformatf("v%0d_done_drop", idx), 270'(Done), 270'(0));
    chk($sformatf("v%0d_busy_start_on_done", idx), 270'(Busy), 270'(start_on_done));
    idle(2);
    chk($sformatf("v%0d_done_count", idx), 270'(done_cnt - d0), 270'(1));
    chk($sformatf("v%0d_color_hold", idx), Color_Out, tv[idx].exp_color);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0;

    tv[0].mode = 0; tv[0].clip = 0; tv[0].exlo = 1; tv[0].exhi = 0;
    tv[0].exp_color = all9({10'd512, 10'd256, 10'd128}); tv[0].exp_mask = 9'h1FF;

    tv[1].mode = 3; tv[1].clip = 0; tv[1].exlo = 1; tv[1].exhi = 0;
    tv[1].exp_color = '0; tv[1].exp_mask = 9'h1FF;

    // Window pixels repeated once more: the saturated count keeps the sum exact.
    tv[2].mode = 1; tv[2].clip = 0; tv[2].exlo = 108; tv[2].exhi = 111;
    tv[2].exp_color = '0; tv[2].exp_color[120 +: 30] = {10'd1023, 20'd0}; tv[2].exp_mask = 9'h1FF;

    // Block 0 at (1,1): window 0..2 in X and Y, 9 hits, 800*9>>4 = 450.
    tv[3].mode = 2; tv[3].clip = 1; tv[3].exlo = 0; tv[3].exhi = 3;
    tv[3].exp_color = all9({10'd800, 20'd0}); tv[3].exp_color[0 +: 30] = {10'd450, 20'd0};
    tv[3].exp_mask = 9'h1FE;

    Reset_n = 1'b0; Start = 1'b0; gotCenters = 1'b0; BlockX = '0; BlockY = '0;
    iSOF = 1'b0; iDVAL = 1'b0; iX = '0; iY = '0; iR = '0; iG = '0; iB = '0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("reset_busy", 270'(Busy), 270'(0));
    chk("reset_done", 270'(Done), 270'(0));
    chk("reset_color", Color_Out, 270'(0));
    chk("reset_mask", 270'(Full_Mask), 270'(0));

    // Start without valid centres is ignored.
    d0 = done_cnt;
    set_centres(1'b0);
    gotCenters = 1'b0;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    chk("nocenters_busy", 270'(Busy), 270'(0));
    pix(1'b1, 110, 110, WHITE);
    repeat (20) pix(1'b0, 109, 109, WHITE);
    pix(1'b1, 110, 110, WHITE);
    idle(4);
    chk("nocenters_no_done", 270'(done_cnt - d0), 270'(0));
    chk("nocenters_mask", 270'(Full_Mask), 270'(0));

    for (int v = 0; v < NV; v++) run_vec(v, v == NV-1);

    // Sampler is armed from the Start on the last Done; abort it mid-frame with reset.
    d0 = done_cnt;
    pix(1'b1, 110, 110, WHITE);
    repeat (30) pix(1'b0, 108, 108, WHITE);
    chk("abort_busy_before_reset", 270'(Busy), 270'(1));
    Reset_n = 1'b0;
    #1;
    chk("abort_busy", 270'(Busy), 270'(0));
    chk("abort_done", 270'(Done), 270'(0));
    chk("abort_color", Color_Out, 270'(0));
    chk("abort_mask", 270'(Full_Mask), 270'(0));
    idle(2);
    Reset_n = 1'b1;
    repeat (10) pix(1'b0, 110, 110, WHITE);
    pix(1'b1, 110, 110, WHITE);
    idle(5);
    chk("abort_no_done", 270'(done_cnt - d0), 270'(0));
    chk("abort_color_after", Color_Out, 270'(0));

    run_vec(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
